seq_div_16by8: RTL
==================

// Module: seq_div_16by8
// PURPOSE
//   Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor -> 2*DW-bit quotient
//   and DW-bit remainder, one quotient bit per clock. This is the inverse datapath of our
//   8x8 Wallace multiplier. It takes a 16-bit product and a multiplier operand and recovers
//   the other operand. Start/done handshake, for use by sequencers that can afford 16-cycle latency.
// PARAMETERS
//   DW   8   divisor/remainder width; dividend and quotient are 2*DW bits; iterations = 2*DW
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   start        in   1      request; sampled only in IDLE or DONE
//   dividend     in   2*DW   sampled on accepted start
//   divisor      in   DW     sampled on accepted start
//   busy         out  1      1 while in RUN
//   done         out  1      1-cycle pulse; results valid
//   quotient     out  2*DW   registered result, held until the next done
//   remainder    out  DW     registered result, held until the next done
//   div_by_zero  out  1      valid with done; held with the results
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; busy, done, quotient, remainder, div_by_zero all 0;
//     internal regs and iteration counter cleared. Reset mid-RUN aborts; no done follows.
//   FSM: IDLE, RUN, DONE.
//     IDLE/DONE + start, divisor!=0 -> RUN: latch dividend into the shift reg,
//       partial rem=0, count=0.
//     IDLE/DONE + start, divisor==0 -> DONE: quotient=all ones, remainder=dividend[DW-1:0],
//       div_by_zero=1.
//     IDLE/DONE, no start -> IDLE.
//     RUN: one step per edge. When count reaches 2*DW-1, that step is last -> DONE.
//       Outputs load on that edge with div_by_zero=0.
//     DONE lasts exactly 1 cycle. done=1 only in DONE.
//   Step (restoring, MSB first): r = {rem[DW-1:0], dq[2*DW-1]} (DW+1 bits); dq <<= 1;
//     if r >= {1'b0,divisor}: rem = r - divisor, dq[0]=1; else rem = r, dq[0]=0.
//     Partial remainder is DW+1 bits wide so the compare never overflows.
//   Latency: accepted start at edge E0. done is high from E(2*DW) to E(2*DW+1),
//     i.e. 16 cycles for DW=8. Divide-by-zero: done is high from E0 to E1.
//   busy=1 from E0 until the edge entering DONE. busy=0 in IDLE and DONE.
//   start while busy is ignored. The operand latches are not disturbed.
//   start in the DONE cycle is accepted (back-to-back). Throughput is 1 result per 2*DW+1 cycles.
//   quotient/remainder/div_by_zero change only on the edge entering DONE.
//   Invariant when div_by_zero=0: quotient*divisor + remainder == dividend, remainder < divisor.
// TESTING
//   1. dividend=100, divisor=7, start 1 cycle -> done exactly 16 cycles later;
//      Q=14, R=2, dz=0; busy high for 16 cycles.
//   2. 0xFFFF/0xFF -> Q=0x0101, R=0. Then 0xFFFF/0x01 -> Q=0xFFFF, R=0.
//      Then 0x0005/0x09 -> Q=0, R=5.
//   3. 0x1234/0 -> done on the next cycle; Q=0xFFFF, R=0x34, dz=1, busy never high.
//   4. start pulsed at cycles 3 and 9 of a RUN with new operands -> first result unchanged.
//      Then start held during the DONE cycle -> new RUN begins, no idle cycle.
//   5. rst asserted mid-RUN (cycle 7) -> all outputs 0 immediately; no done pulse.
//      Next start computes correctly.
//   6. 1000 random a,b (b!=0): dividend=a*b, divisor=b -> Q=a, R=0.
//      Plus random 16/8 pairs checked against the invariant.

Source files
------------

// File: rtl/seq_div_16by8_if.sv
// Handshake and operand/result bundle for the sequential 2*DW/DW restoring divider.
interface seq_div_16by8_if #(parameter int DW = 8);
  logic              start;
  logic [2*DW-1:0]   dividend;
  logic [DW-1:0]     divisor;
  logic              busy;
  logic              done;
  logic [2*DW-1:0]   quotient;
  logic [DW-1:0]     remainder;
  logic              div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div_16by8.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, 2*DW iterations.
// Recovers a multiplier operand from a 16-bit product; divide-by-zero finishes in one cycle.
module seq_div_16by8 #(
  parameter int DW = 8
) (
  input logic             clk,
  input logic             rst,
  seq_div_16by8_if.slave  bus
);

  localparam int QW = 2 * DW;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, next_state;
  logic [QW-1:0]   dq, dq_next;
  logic [DW-1:0]   rem, rem_next, dvs;
  logic [CW-1:0]   count;
  logic [DW:0]     r, diff;
  logic            ge;
  logic            accept;
  logic [QW-1:0]   q_reg;
  logic [DW-1:0]   r_reg;
  logic            dz_reg;

  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;

  // r never exceeds 2*divisor-1, so the sign of r-divisor in DW+1 bits is exactly r < divisor.
  always_comb begin
    r        = {rem, dq[QW-1]};
    diff     = r - {1'b0, dvs};
    ge       = ~diff[DW];
    rem_next = ge ? diff[DW-1:0] : r[DW-1:0];
    dq_next  = {dq[QW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) next_state = (bus.divisor == '0) ? DONE : RUN;
        else           next_state = IDLE;
      end
      RUN:     if (count == LAST) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Operands are only latched on an accepted start, so start pulses during RUN are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq     <= '0;
      rem    <= '0;
      dvs    <= '0;
      count  <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      dz_reg <= 1'b0;
    end else if (accept) begin
      if (bus.divisor != '0) begin
        dq    <= bus.dividend;
        dvs   <= bus.divisor;
        rem   <= '0;
        count <= '0;
      end else begin
        q_reg  <= '1;
        r_reg  <= bus.dividend[DW-1:0];
        dz_reg <= 1'b1;
      end
    end else if (state == RUN) begin
      dq    <= dq_next;
      rem   <= rem_next;
      count <= count + CW'(1);
      if (count == LAST) begin
        q_reg  <= dq_next;
        r_reg  <= rem_next;
        dz_reg <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;
  assign bus.div_by_zero = dz_reg;

endmodule
